// File: rtl/mips_display_scanner.sv
// Display output stage for the multicycle MIPS core.
// Scans an 8-digit active-low seven-segment display with the core's PC, data
// word or control state. One button cycles the view and the other freezes a
// snapshot of the inputs while the core keeps running.
module mips_display_scanner #(
    parameter int REFRESH_DIV     = 50000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic [31:0] data,
    input  logic [3:0]  state,
    input  logic        btn_view,
    input  logic        btn_freeze,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  view
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0] PS_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        VIEW_PC    = 2'd0,
        VIEW_DATA  = 2'd1,
        VIEW_STATE = 2'd2,
        VIEW_BAD   = 2'd3
    } view_t;

    // Bit 0 is the view button, bit 1 is the freeze button.
    logic [1:0] btn_raw;
    logic [1:0] press_pulse;

    assign btn_raw = {btn_freeze, btn_view};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic          sync1_reg;
            logic          sync2_reg;
            logic          stable_reg;
            logic [CW-1:0] cnt_reg;

            // Two-flop synchronizer followed by a stable-level debounce counter.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    sync1_reg  <= 1'b0;
                    sync2_reg  <= 1'b0;
                    stable_reg <= 1'b0;
                    cnt_reg    <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == stable_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        stable_reg <= sync2_reg;
                        cnt_reg    <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
            end

            // Press is flagged in the cycle whose edge moves stable from 0 to 1,
            // so downstream state reacts on the same edge the level is accepted.
            assign press_pulse[gi] = sync2_reg & ~stable_reg & (cnt_reg == DB_LAST);
        end
    endgenerate

    logic [PW-1:0] prescale_reg;
    logic [2:0]    index_reg;
    view_t         view_reg;
    logic          frozen_reg;
    logic [31:0]   snap_pc_reg;
    logic [31:0]   snap_data_reg;
    logic [3:0]    snap_state_reg;

    // Scan prescaler: each digit is driven for REFRESH_DIV cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prescale_reg <= '0;
            index_reg    <= 3'd0;
        end else if (prescale_reg == PS_LAST) begin
            prescale_reg <= '0;
            index_reg    <= index_reg + 3'd1;
        end else begin
            prescale_reg <= prescale_reg + PW'(1);
        end
    end

    // View FSM and freeze toggle; both pulses may act on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            view_reg   <= VIEW_PC;
            frozen_reg <= 1'b0;
        end else begin
            case (view_reg)
                VIEW_PC:    if (press_pulse[0]) view_reg <= VIEW_DATA;
                VIEW_DATA:  if (press_pulse[0]) view_reg <= VIEW_STATE;
                VIEW_STATE: if (press_pulse[0]) view_reg <= VIEW_PC;
                default:    view_reg <= VIEW_PC;
            endcase
            if (press_pulse[1]) begin
                frozen_reg <= ~frozen_reg;
            end
        end
    end

    // Snapshot tracks the core while unfrozen; frozen_reg is still 0 on the
    // freezing edge, so that edge's inputs are the ones captured.
    always_ff @(posedge clk) begin
        if (!rst) begin
            snap_pc_reg    <= 32'h0;
            snap_data_reg  <= 32'h0;
            snap_state_reg <= 4'h0;
        end else if (!frozen_reg) begin
            snap_pc_reg    <= pc;
            snap_data_reg  <= data;
            snap_state_reg <= state;
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0: code = 7'h40;
            4'h1: code = 7'h79;
            4'h2: code = 7'h24;
            4'h3: code = 7'h30;
            4'h4: code = 7'h19;
            4'h5: code = 7'h12;
            4'h6: code = 7'h02;
            4'h7: code = 7'h78;
            4'h8: code = 7'h00;
            4'h9: code = 7'h10;
            4'hA: code = 7'h08;
            4'hB: code = 7'h03;
            4'hC: code = 7'h46;
            4'hD: code = 7'h21;
            4'hE: code = 7'h06;
            default: code = 7'h0E;
        endcase
        return code;
    endfunction

    logic [31:0] word_sel;
    logic        blank;
    logic [3:0]  nibble;
    logic [6:0]  seg_next;

    // Select the displayed word and the nibble for the current digit.
    always_comb begin
        word_sel = snap_pc_reg;
        blank    = 1'b0;
        case (view_reg)
            VIEW_DATA: word_sel = snap_data_reg;
            VIEW_STATE: begin
                word_sel = {28'h0, snap_state_reg};
                blank    = (index_reg != 3'd0);
            end
            default: word_sel = snap_pc_reg;
        endcase
        nibble   = word_sel[{index_reg, 2'b00} +: 4];
        seg_next = blank ? 7'h7F : hex7(nibble);
    end

    logic [7:0] an_reg;
    logic [6:0] seg_reg;
    logic       dp_reg;

    // Registered display drivers; dark during reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            an_reg  <= 8'hFF;
            seg_reg <= 7'h7F;
            dp_reg  <= 1'b1;
        end else begin
            an_reg  <= ~(8'h01 << index_reg);
            seg_reg <= seg_next;
            dp_reg  <= ~(frozen_reg && (index_reg == 3'd7));
        end
    end

    assign an   = an_reg;
    assign seg  = seg_reg;
    assign dp   = dp_reg;
    assign view = view_reg;

endmodule

// File: tb/tb_mips_display_scanner.sv
// Directed testbench for mips_display_scanner with a short refresh period
// and short debounce so every scenario fits in a few hundred cycles.
module tb_mips_display_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] data;
    logic [3:0]  state;
    logic        btn_view;
    logic        btn_freeze;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  view;

    int vectors     = 0;
    int miscompares = 0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    mips_display_scanner #(
        .REFRESH_DIV    (4),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .data      (data),
        .state     (state),
        .btn_view  (btn_view),
        .btn_freeze(btn_freeze),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .view      (view)
    );

    // Advance n rising edges and settle on the following falling edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        btn_view   = 1'b0;
        btn_freeze = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    task automatic press_btn(input logic v, input logic f);
        btn_view   = v;
        btn_freeze = f;
        tick(6);
        btn_view   = 1'b0;
        btn_freeze = 1'b0;
        tick(8);
    endtask

    // Returns the digit selected by a one-cold enable pattern, 8 if malformed.
    function automatic int an_digit(input logic [7:0] a);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) begin
            m = 8'h01 << i;
            if (a == ~m) return i;
        end
        return 8;
    endfunction

    task automatic test_reset();
        pc    = 32'h0040_001C;
        data  = 32'hDEAD_BEEF;
        state = 4'h7;
        do_reset();
        rst = 1'b0;
        tick(2);
        vectors++; if (an !== 8'hFF) begin miscompares++; $display("FAIL reset_an got %h want ff", an); end
        vectors++; if (seg !== 7'h7F) begin miscompares++; $display("FAIL reset_seg got %h want 7f", seg); end
        vectors++; if (dp !== 1'b1) begin miscompares++; $display("FAIL reset_dp got %b want 1", dp); end
        vectors++; if (view !== 2'd0) begin miscompares++; $display("FAIL reset_view got %0d want 0", view); end
        rst = 1'b1;
        tick(1);
        vectors++; if (an !== 8'hFE) begin miscompares++; $display("FAIL release_an got %h want fe", an); end
        tick(1);
        vectors++; if (seg !== 7'h46) begin miscompares++; $display("FAIL release_seg got %h want 46", seg); end
        vectors++; if (dp !== 1'b1) begin miscompares++; $display("FAIL release_dp got %b want 1", dp); end
        $display("test_reset done");
    endtask

    task automatic test_scan();
        logic [6:0] seg_exp [8] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
        logic [7:0] an_exp;
        pc = 32'h8765_4321;
        do_reset();
        for (int d = 0; d < 8; d++) begin
            for (int k = 0; k < 4; k++) begin
                tick(1);
                an_exp = ~(8'h01 << d);
                vectors++;
                if (an !== an_exp) begin
                    miscompares++;
                    $display("FAIL scan_an d=%0d k=%0d got %h want %h", d, k, an, an_exp);
                end
                if (!(d == 0 && k == 0)) begin
                    vectors++;
                    if (seg !== seg_exp[d]) begin
                        miscompares++;
                        $display("FAIL scan_seg d=%0d k=%0d got %h want %h", d, k, seg, seg_exp[d]);
                    end
                end
            end
        end
        tick(1);
        vectors++; if (an !== 8'hFE) begin miscompares++; $display("FAIL scan_wrap_an got %h want fe", an); end
        $display("test_scan done");
    endtask

    task automatic test_debounce();
        pc = 32'h0;
        do_reset();
        btn_view = 1'b1;
        tick(2);
        btn_view = 1'b0;
        tick(10);
        vectors++; if (view !== 2'd0) begin miscompares++; $display("FAIL short_press got %0d want 0", view); end
        btn_view = 1'b1;
        tick(4);
        vectors++; if (view !== 2'd0) begin miscompares++; $display("FAIL press_early got %0d want 0", view); end
        tick(1);
        vectors++; if (view !== 2'd1) begin miscompares++; $display("FAIL press_accept got %0d want 1", view); end
        tick(10);
        vectors++; if (view !== 2'd1) begin miscompares++; $display("FAIL press_hold got %0d want 1", view); end
        btn_view = 1'b0;
        tick(8);
        vectors++; if (view !== 2'd1) begin miscompares++; $display("FAIL release got %0d want 1", view); end
        press_btn(1'b1, 1'b0);
        vectors++; if (view !== 2'd2) begin miscompares++; $display("FAIL view_state got %0d want 2", view); end
        press_btn(1'b1, 1'b0);
        vectors++; if (view !== 2'd0) begin miscompares++; $display("FAIL view_wrap got %0d want 0", view); end
        $display("test_debounce done");
    endtask

    task automatic test_state_view();
        int d;
        logic [6:0] exp;
        pc    = 32'h1111_1111;
        state = 4'hA;
        do_reset();
        press_btn(1'b1, 1'b0);
        press_btn(1'b1, 1'b0);
        vectors++; if (view !== 2'd2) begin miscompares++; $display("FAIL state_view got %0d want 2", view); end
        for (int c = 0; c < 36; c++) begin
            tick(1);
            d = an_digit(an);
            exp = (d == 0) ? 7'h08 : 7'h7F;
            vectors++;
            if (d == 8 || seg !== exp) begin
                miscompares++;
                $display("FAIL state_seg an=%h got %h want %h", an, seg, exp);
            end
        end
        $display("test_state_view done");
    endtask

    task automatic test_freeze();
        int d;
        logic [31:0] w;
        logic [6:0] exp;
        logic       dp_exp;
        pc    = 32'h0;
        state = 4'h0;
        data  = 32'h1234_5678;
        w     = 32'h1234_5678;
        do_reset();
        press_btn(1'b1, 1'b0);
        vectors++; if (view !== 2'd1) begin miscompares++; $display("FAIL freeze_view got %0d want 1", view); end
        press_btn(1'b0, 1'b1);
        data = 32'h0;
        tick(2);
        for (int c = 0; c < 36; c++) begin
            tick(1);
            d = an_digit(an);
            exp = (d < 8) ? hex_tab[w[4*d +: 4]] : 7'h7F;
            dp_exp = (d == 7) ? 1'b0 : 1'b1;
            vectors++;
            if (d == 8 || seg !== exp || dp !== dp_exp) begin
                miscompares++;
                $display("FAIL frozen_disp an=%h got seg %h dp %b want seg %h dp %b", an, seg, dp, exp, dp_exp);
            end
        end
        press_btn(1'b0, 1'b1);
        for (int c = 0; c < 36; c++) begin
            tick(1);
            d = an_digit(an);
            vectors++;
            if (d == 8 || seg !== 7'h40 || dp !== 1'b1) begin
                miscompares++;
                $display("FAIL unfrozen_disp an=%h got seg %h dp %b want seg 40 dp 1", an, seg, dp);
            end
        end
        $display("test_freeze done");
    endtask

    task automatic test_simultaneous();
        int d;
        logic [31:0] w;
        logic [6:0] exp;
        logic       dp_exp;
        pc   = 32'hFEDC_BA98;
        w    = 32'hFEDC_BA98;
        data = 32'hAAAA_AAAA;
        do_reset();
        btn_view   = 1'b1;
        btn_freeze = 1'b1;
        tick(4);
        vectors++; if (view !== 2'd0) begin miscompares++; $display("FAIL both_early got %0d want 0", view); end
        tick(1);
        vectors++; if (view !== 2'd1) begin miscompares++; $display("FAIL both_view got %0d want 1", view); end
        data = 32'h0;
        tick(1);
        btn_view   = 1'b0;
        btn_freeze = 1'b0;
        tick(8);
        for (int c = 0; c < 36; c++) begin
            tick(1);
            d = an_digit(an);
            dp_exp = (d == 7) ? 1'b0 : 1'b1;
            vectors++;
            if (d == 8 || seg !== 7'h08 || dp !== dp_exp) begin
                miscompares++;
                $display("FAIL both_frozen an=%h got seg %h dp %b want seg 08 dp %b", an, seg, dp, dp_exp);
            end
        end
        btn_view   = 1'b1;
        btn_freeze = 1'b1;
        tick(3);
        rst        = 1'b0;
        btn_view   = 1'b0;
        btn_freeze = 1'b0;
        tick(2);
        vectors++; if (an !== 8'hFF) begin miscompares++; $display("FAIL midreset_an got %h want ff", an); end
        vectors++; if (seg !== 7'h7F) begin miscompares++; $display("FAIL midreset_seg got %h want 7f", seg); end
        vectors++; if (dp !== 1'b1) begin miscompares++; $display("FAIL midreset_dp got %b want 1", dp); end
        vectors++; if (view !== 2'd0) begin miscompares++; $display("FAIL midreset_view got %0d want 0", view); end
        rst = 1'b1;
        tick(1);
        vectors++; if (an !== 8'hFE) begin miscompares++; $display("FAIL midreset_release_an got %h want fe", an); end
        for (int c = 0; c < 36; c++) begin
            tick(1);
            d = an_digit(an);
            exp = (d < 8) ? hex_tab[w[4*d +: 4]] : 7'h7F;
            vectors++;
            if (d == 8 || seg !== exp || dp !== 1'b1) begin
                miscompares++;
                $display("FAIL post_reset_disp an=%h got seg %h dp %b want seg %h dp 1", an, seg, dp, exp);
            end
        end
        $display("test_simultaneous done");
    endtask

    initial begin
        rst        = 1'b0;
        pc         = 32'h0;
        data       = 32'h0;
        state      = 4'h0;
        btn_view   = 1'b0;
        btn_freeze = 1'b0;
        test_reset();
        test_scan();
        test_debounce();
        test_state_view();
        test_freeze();
        test_simultaneous();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
